// File: rtl/sram_pkg.sv
// Shared constants and types for the sram_ctl on-chip buffer.
package sram_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 25;
   localparam int DEPTH  = 1024;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;

endpackage : sram_pkg

// File: rtl/sram_mem_array.sv
// Pure word storage with a registered read port and no reset, so that a
// synthesis tool can map it onto block RAM. On a write cycle the port is
// write-first: rdata takes the new word on the same edge.
module sram_mem_array #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // One access per edge: write (with write-through to rdata) or read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
         rdata    <= wdata;
      end else begin
         rdata <= mem[idx];
      end
   end

endmodule : sram_mem_array

// File: rtl/sram_ctl.sv
// Single-port synchronous SRAM wrapper. Owns the address range check, the
// per-word valid bits (cleared by reset so stale contents read as zero) and
// the output gate in front of the storage array.
//
// Timing contract: address/write_en/data_in are sampled on every rising edge
// (no handshake, one operation per cycle); data_out reflects that operation
// for the whole following cycle and is driven only from registers.
module sram_ctl #(
   parameter int DATA_W = sram_pkg::DATA_W,
   parameter int ADDR_W = sram_pkg::ADDR_W,
   parameter int DEPTH  = sram_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic [ADDR_W-1:0] address,
   input  logic              write_en,
   output logic [DATA_W-1:0] data_out
);

   // DEPTH is a power of two, so the index is the low address bits and any
   // set bit above them means the address is out of range.
   localparam int IDX_W = $clog2(DEPTH);

   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic              mem_we;
   logic [DEPTH-1:0]  valid;
   logic              out_en_q;
   logic [DATA_W-1:0] mem_rdata;

   assign in_range = (address >> IDX_W) == '0;
   assign idx      = address[IDX_W-1:0];

   // Reset has priority: a write presented during reset never reaches the array.
   assign mem_we   = rst && write_en && in_range;

   sram_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .idx   (idx),
      .wdata (data_in),
      .rdata (mem_rdata)
   );

   // Valid bits: cleared by reset, set by every in-range write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= '0;
      end else if (mem_we) begin
         valid[idx] <= 1'b1;
      end
   end

   // Output enable: pass the array word only for in-range writes and for
   // in-range reads of a word written since reset; otherwise force zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_en_q <= 1'b0;
      end else begin
         out_en_q <= in_range && (write_en || valid[idx]);
      end
   end

   assign data_out = out_en_q ? mem_rdata : '0;

endmodule : sram_ctl

// File: tb/tb_sram_ctl.sv
// Directed bench for sram_ctl: a word-level reference model plus scoreboard
// checked every cycle, and literal expectations at key points.
module tb_sram_ctl;
   import sram_pkg::*;

   localparam int TB_DEPTH = 1024;

   logic  clk;
   logic  rst;
   data_t data_in;
   addr_t address;
   logic  write_en;
   data_t data_out;

   int n_checks = 0;
   int n_errors = 0;

   data_t exp_q[$];
   data_t model_mem[int unsigned];

   localparam data_t BASE = 64'h1122334455667788;
   localparam data_t PAT_A = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam data_t PAT_B = 64'h5555_5555_5555_5555;

   sram_ctl #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (TB_DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .address  (address),
      .write_en (write_en),
      .data_out (data_out)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
      $fatal(1, "watchdog");
   end

   // Reference model: a sparse word map; reset forgets every word.
   function automatic data_t model_step(input logic r, input logic we,
                                        input addr_t a, input data_t d);
      int unsigned ai;
      ai = int'(a);
      if (!r) begin
         model_mem.delete();
         return '0;
      end
      if (ai >= TB_DEPTH) return '0;
      if (we) begin
         model_mem[ai] = d;
         return d;
      end
      if (model_mem.exists(ai)) return model_mem[ai];
      return '0;
   endfunction

   task automatic check(input string name, input data_t got, input data_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
      end
   endtask

   // Driver: present one operation for the next rising edge and record
   // the model's expected data_out for it.
   task automatic op(input logic r, input logic we, input addr_t a, input data_t d);
      @(negedge clk);
      rst      = r;
      write_en = we;
      address  = a;
      data_in  = d;
      exp_q.push_back(model_step(r, we, a, d));
   endtask

   // Literal expectation on the result of the operation just issued.
   task automatic expect_lit(input string name, input data_t exp);
      @(posedge clk);
      #2;
      check(name, data_out, exp);
   endtask

   // Scoreboard: every edge with an issued operation is compared.
   initial begin
      data_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stream", data_out, e);
         end
      end
   end

   initial begin
      rst      = 1'b0;
      write_en = 1'b0;
      address  = '0;
      data_in  = '0;

      // 1. reset with a write presented: ignored, output zero
      op(1'b0, 1'b1, 25'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      op(1'b0, 1'b1, 25'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      expect_lit("reset_out", 64'h0);
      op(1'b1, 1'b0, 25'd0, '0);
      expect_lit("read0_after_reset", 64'h0);

      // 2. write sweep then read sweep
      for (int i = 0; i < 32; i++) op(1'b1, 1'b1, addr_t'(i), BASE ^ data_t'(i));
      expect_lit("write31_through", 64'h1122334455667797);
      for (int i = 0; i < 32; i++) op(1'b1, 1'b0, addr_t'(i), $urandom());
      expect_lit("read31", 64'h1122334455667797);

      // 3. unwritten word, then write and read back
      op(1'b1, 1'b0, 25'd500, '0);
      expect_lit("read500_unwritten", 64'h0);
      op(1'b1, 1'b1, 25'd500, 64'h0123456789ABCDEF);
      op(1'b1, 1'b0, 25'd500, '0);
      expect_lit("read500", 64'h0123456789ABCDEF);

      // 4. out of range: no write, no aliasing
      op(1'b1, 1'b1, 25'd1024, 64'hDEAD_BEEF_0000_0001);
      expect_lit("write1024", 64'h0);
      op(1'b1, 1'b0, 25'd1024, '0);
      expect_lit("read1024", 64'h0);
      op(1'b1, 1'b0, 25'd0, '0);
      expect_lit("read0_no_alias", 64'h1122334455667788);
      op(1'b1, 1'b0, 25'd1027, '0);
      expect_lit("read1027", 64'h0);
      op(1'b1, 1'b1, 25'h1FF_FFFF, 64'h1234);
      op(1'b1, 1'b0, 25'd1023, '0);
      expect_lit("read1023_unwritten", 64'h0);

      // 5. overwrite back to back
      op(1'b1, 1'b1, 25'd7, PAT_A);
      expect_lit("seq_a", PAT_A);
      op(1'b1, 1'b1, 25'd7, PAT_B);
      expect_lit("seq_b", PAT_B);
      op(1'b1, 1'b0, 25'd7, '0);
      expect_lit("seq_read_b", PAT_B);

      // 6. reset during a write, then everything reads zero
      op(1'b1, 1'b1, 25'd2, 64'h22);
      op(1'b0, 1'b1, 25'd3, 64'hCAFE_F00D_CAFE_F00D);
      expect_lit("reset_mid_write", 64'h0);
      for (int i = 0; i < 32; i++) op(1'b1, 1'b0, addr_t'(i), '0);
      op(1'b1, 1'b0, 25'd3, '0);
      expect_lit("read3_after_reset", 64'h0);
      op(1'b1, 1'b0, 25'd500, '0);
      expect_lit("read500_after_reset", 64'h0);
      op(1'b1, 1'b1, 25'd10, 64'h0A0A);
      op(1'b1, 1'b0, 25'd10, '0);
      expect_lit("read10_rewritten", 64'h0A0A);
      op(1'b1, 1'b0, 25'd11, '0);
      expect_lit("read11_after_reset", 64'h0);

      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_sram_ctl
